// File: rtl/crc_table_ram.sv
// crc_table_ram: dual-port RAM that fills itself with a CRC lookup table.
//
// Entry idx of the table is the CRC remainder of the ADDR_W-bit value idx,
// aligned to the top of a DATA_W-bit register and then shifted ADDR_W times
// through the generator polynomial. With the defaults (8-bit data, 8-bit
// address, POLY = 0x07) this is the familiar CRC-8 byte table.
//
// After reset (and on every init_req seen while idle) a small FSM computes
// one entry per ADDR_W+2 cycles and writes it through a dedicated fill port.
// While the fill runs, init_busy is high and both user ports are locked out.
// With INIT_EN = 0 the block is a plain dual-port RAM with undefined
// power-up contents.
//
// Port behaviour:
//   - An access happens only when chipselect, clken are high and init_busy is low.
//   - Reads have one cycle of latency; readdata holds until the next read.
//   - A write never disturbs the same port's readdata (read-first).
//   - A read on one port that collides with a write on the other port
//     returns the old contents.
//   - When both ports write one address in the same cycle, port 1 wins.

module crc_table_ram #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [DATA_W-1:0] POLY    = DATA_W'(8'h07),
  parameter bit                INIT_EN = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_clken,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,

  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_clken,
  input  logic              s2_write,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,

  input  logic              init_req,
  output logic              init_busy
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------

  // Left shift that places the table index in the top ADDR_W bits of r.
  localparam int SHIFT_IN = DATA_W - ADDR_W;

  // Bit counter only needs to reach ADDR_W-1; the extra bit keeps the
  // width non-zero when ADDR_W is 1.
  localparam int                CNT_W    = $clog2(ADDR_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(ADDR_W - 1);
  localparam logic [ADDR_W-1:0] IDX_MAX  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    INIT_LOAD,
    INIT_SHIFT,
    INIT_WRITE,
    READY
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and fill state
  // ---------------------------------------------------------------------------

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  state_t            state;
  logic [ADDR_W-1:0] idx;       // table entry being computed
  logic [DATA_W-1:0] r;         // CRC shift register for the current entry
  logic [CNT_W-1:0]  bit_cnt;   // shift steps already taken for this entry

  // ---------------------------------------------------------------------------
  // Access qualification
  // ---------------------------------------------------------------------------

  logic s1_en, s1_we, s1_re;
  logic s2_en, s2_we, s2_re;
  logic fill_we;

  // init_busy is a register, so the lock-out takes effect on the cycle after
  // a request is accepted; accesses in the request cycle itself still happen.
  assign s1_en   = s1_chipselect & s1_clken & ~init_busy;
  assign s1_we   = s1_en &  s1_write;
  assign s1_re   = s1_en & ~s1_write;

  assign s2_en   = s2_chipselect & s2_clken & ~init_busy;
  assign s2_we   = s2_en &  s2_write;
  assign s2_re   = s2_en & ~s2_write;

  // Only the fill FSM writes while busy, so this never overlaps a port write.
  assign fill_we = (state == INIT_WRITE);

  // ---------------------------------------------------------------------------
  // Table fill FSM: load index, shift ADDR_W times, write entry, repeat.
  // ---------------------------------------------------------------------------

  // Fill sequencer with registered init_busy; reset restarts the fill at idx 0.
  always_ff @(posedge clk_clk) begin
    // NOTE: every register in a clocked block is assigned with <= so that all
    // of them sample pre-edge values; a blocking = here would let later
    // statements see the new value and change the hardware that is inferred.
    if (reset_reset) begin
      state     <= INIT_EN ? INIT_LOAD : READY;
      init_busy <= INIT_EN;
      idx       <= '0;
      r         <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        INIT_LOAD: begin
          r       <= DATA_W'(idx) << SHIFT_IN;
          bit_cnt <= '0;
          state   <= INIT_SHIFT;
        end

        INIT_SHIFT: begin
          // One step of polynomial division; the MSB shifted out stands for
          // the implicit top bit of the generator.
          r <= r[DATA_W-1] ? ((r << 1) ^ POLY) : (r << 1);
          if (bit_cnt == LAST_BIT) begin
            state <= INIT_WRITE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        INIT_WRITE: begin
          if (idx == IDX_MAX) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= INIT_LOAD;
          end
        end

        READY: begin
          // Requests during a fill never reach this branch, so they are ignored.
          if (init_req && INIT_EN) begin
            state     <= INIT_LOAD;
            idx       <= '0;
            init_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------

  // RAM writes: fill port, then port 2, then port 1 so port 1 wins a collision.
  always_ff @(posedge clk_clk) begin
    // NOTE: the array deliberately has no reset branch. Resetting it would turn
    // the RAM into thousands of flops; reset only blocks writes for that cycle,
    // so entries written before a mid-fill reset keep their values.
    if (!reset_reset) begin
      if (fill_we) begin
        mem[idx] <= r;
      end
      if (s2_we) begin
        mem[s2_address] <= s2_writedata;
      end
      if (s1_we) begin
        mem[s1_address] <= s1_writedata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read data
  // ---------------------------------------------------------------------------

  // Port 1 read register: loads only on a qualified read, otherwise holds.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_readdata <= '0;
    end else if (s1_re) begin
      s1_readdata <= mem[s1_address];
    end
  end

  // Port 2 read register: loads only on a qualified read, otherwise holds.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s2_readdata <= '0;
    end else if (s2_re) begin
      s2_readdata <= mem[s2_address];
    end
  end

endmodule
